// File: rtl/gate_pkg.sv
// Shared types and constants for the two-input gate sweep tester.
package gate_pkg;
  localparam int NUM_VEC = 4;

  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_XOR = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/gate_tester_settle_timer.sv
// Loadable 4-bit down-counter that paces how long each vector is held.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/gate_tester.sv
// Sweeps all four (a,b) vectors into a gate under test and checks x against TRUTH.
// Optional GATE_TESTER_FAILMASK_EN adds a per-vector fail_mask output.
module gate_tester
  import gate_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_OR,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
`ifdef GATE_TESTER_FAILMASK_EN
  ,
  output logic [3:0] fail_mask
`endif
);
  localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

  state_e     state;
  logic [1:0] idx;
  logic       zero;
  logic       accept, sample, mism;

  assign accept = (state == IDLE) && start;
  assign sample = (state == RUN) && zero;
  assign mism   = (x != TRUTH[idx]);

  // a,b come straight from idx so they only move on accept/sample edges
  assign a = idx[0];
  assign b = idx[1];

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept | sample),
    .load_val (LOAD_VAL),
    .dec      (state == RUN),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          idx     <= '0;
          busy    <= 1'b1;
          pass    <= 1'b0;
          err_cnt <= '0;
        end
        RUN: if (zero) begin
          if (mism) err_cnt <= err_cnt + 3'd1;
          // last vector stays on a,b after the sweep
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == '0) && !mism;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_TESTER_FAILMASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fail_mask      <= '0;
    else if (accept)         fail_mask      <= '0;
    else if (sample && mism) fail_mask[idx] <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_gate_tester.sv
// Bench: three tester instances (OR/S2, AND/S2, OR/S1) driving an OR gate model with injected faults.
module tb_gate_tester;
  import gate_pkg::*;

  typedef struct packed {
    logic       a, b, busy, done, pass;
    logic [2:0] err;
    logic [3:0] fm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]      start, a, b, x, busy, done, pass;
  logic [2:0][2:0] err_cnt;
  logic [2:0][3:0] fail_mask;
  logic [2:0][3:0] corrupt;
  int n_chk, n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_tester #(
      .TRUTH  (g == 1 ? TT_AND : TT_OR),
      .SETTLE (g == 2 ? 1 : 2)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start[g]),
      .a       (a[g]),
      .b       (b[g]),
      .x       (x[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .pass    (pass[g]),
      .err_cnt (err_cnt[g])
`ifdef GATE_TESTER_FAILMASK_EN
      ,
      .fail_mask (fail_mask[g])
`endif
    );
    // OR gate under test, with per-vector fault injection
    assign x[g] = (a[g] | b[g]) ^ corrupt[g][{b[g], a[g]}];
  end

`ifndef GATE_TESTER_FAILMASK_EN
  assign fail_mask = '0;
`endif

  function automatic int settle_of(int g);
    return (g == 2) ? 1 : 2;
  endfunction

  function automatic logic [3:0] truth_of(int g);
    return (g == 1) ? TT_AND : TT_OR;
  endfunction

  // Expected outputs t cycles after the start-accept edge, from the sweep schedule
  function automatic exp_t model(int t, int s, logic [3:0] tr, logic [3:0] c);
    exp_t e;
    logic [3:0] resp;
    int v;
    e = '0;
    resp = TT_OR ^ c;
    v = t / s;
    if (v > 3) v = 3;
    e.a = v[0];
    e.b = v[1];
    for (int i = 0; i < 4; i++)
      if ((i + 1) * s <= t && resp[i] != tr[i]) begin
        e.err   = e.err + 3'd1;
        e.fm[i] = 1'b1;
      end
    e.busy = (t < 4 * s);
    e.done = (t == 4 * s);
    e.pass = (t >= 4 * s) && (e.err == 3'd0);
`ifndef GATE_TESTER_FAILMASK_EN
    e.fm = '0;
`endif
    return e;
  endfunction

  function automatic exp_t obs(int g);
    exp_t o;
    o.a = a[g]; o.b = b[g]; o.busy = busy[g]; o.done = done[g]; o.pass = pass[g];
    o.err = err_cnt[g];
    o.fm  = fail_mask[g];
    return o;
  endfunction

  task automatic chk(input string tag, input int g, input int t, input exp_t e);
    exp_t o;
    o = obs(g);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0d observed=%h expected=%h", tag, g, t, o, e);
    end
  endtask

  // Call and return at a negedge. pulse>0: extra start pulse sampled at edge k+pulse.
  task automatic sweep(input string tag, input int g, input logic [3:0] c, input int pulse);
    int s;
    logic [3:0] tr;
    s  = settle_of(g);
    tr = truth_of(g);
    corrupt[g] = c;
    start[g]   = 1'b1;
    @(negedge clk);
    start[g] = (pulse == 1);
    chk(tag, g, 0, model(0, s, tr, c));
    for (int t = 1; t <= 4 * s + 2; t++) begin
      @(negedge clk);
      chk(tag, g, t, model(t, s, tr, c));
      start[g] = (t + 1 == pulse);
    end
  endtask

  initial begin
    exp_t z;
    int   g, p;
    logic seen;
    logic [3:0] c;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = '0; corrupt = '0;
    z = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset", i, 0, z);

    rst_n = 1'b1;
    sweep("or_clean", 0, 4'b0000, -1);
    sweep("x_tied0", 0, 4'b1110, -1);
    sweep("and_truth", 1, 4'b0000, -1);
    sweep("start_in_run", 0, 4'b0000, 3);
    sweep("start_in_done", 0, 4'b0100, 9);

    // Reset mid-sweep
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 0, 5, z);
    @(negedge clk);
    chk("rst_hold", 0, 6, z);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1'b1;
    end
    n_chk++;
    assert (seen === 1'b0) else begin
      n_fail++;
      $error("FAIL no_done_after_rst observed=%b expected=0", seen);
    end
    sweep("after_rst", 0, 4'b0000, -1);

    // SETTLE=1, start held high: back-to-back sweeps, restart at k+6
    corrupt[2] = 4'b0000;
    start[2]   = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 5; t++) begin
      if (t > 0) @(negedge clk);
      chk("held_1st", 2, t, model(t, 1, TT_OR, 4'b0000));
    end
    corrupt[2] = 4'b0101;
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      chk("held_2nd", 2, t, model(t, 1, TT_OR, 4'b0101));
      if (t == 4) start[2] = 1'b0;
    end

    // Randomized sweeps
    repeat (12) begin
      g = $urandom_range(0, 2);
      c = 4'($urandom);
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4 * settle_of(g) + 1) : -1;
      sweep("random", g, c, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
